// File: rtl/cache_pkg.sv
// Shared types, default widths and address field helpers for the direct-mapped cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INDEX_W = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag array plus valid vector: registered read, single write port, one-cycle clear of all valid bits.
module cache_tag_store #(
  parameter int unsigned INDEX_W = cache_pkg::INDEX_W,
  parameter int unsigned TAG_W   = cache_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               gen_reset,
  input  logic               clear_all,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int unsigned DEPTH = 2 ** INDEX_W;

  logic [TAG_W-1:0] tags [DEPTH];
  logic [DEPTH-1:0] valid;

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (gen_reset || clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      rd_tag   <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_tag   <= tags[rd_idx];
      rd_valid <= valid[rd_idx];
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of an external data RAM.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl #(
  parameter int unsigned ADDR_W  = cache_pkg::ADDR_W,
  parameter int unsigned INDEX_W = cache_pkg::INDEX_W,
  parameter int unsigned DATA_W  = cache_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               gen_reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               flush,
  output logic               ram_we,
  output logic               ram_re,
  output logic [INDEX_W-1:0] ram_addr,
  output logic [DATA_W-1:0]  ram_din,
  input  logic [DATA_W-1:0]  ram_dout,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  import cache_pkg::*;

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  state_t   state_q, state_d;
  cpu_req_t req_q;

  logic               accept_c;
  logic               flush_c;
  logic               lookup_c;
  logic               hit_c;
  logic               tag_we_c;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;

  logic               cpu_ready_d;
  logic [DATA_W-1:0]  cpu_rdata_d;
  logic               ram_we_d;
  logic [DATA_W-1:0]  ram_din_d;
  logic               mem_req_d;
  logic               mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d;

  assign flush_c  = (state_q == IDLE) && flush;
  assign accept_c = (state_q == IDLE) && cpu_req && !flush;
  assign idx_q    = get_index(req_q.addr);
  assign tag_q    = get_tag(req_q.addr);
  assign hit_c    = rd_valid && (rd_tag == tag_q);

  // The RAM registers its read on the accepting edge, so read strobe and address must be
  // presented combinationally in IDLE for ram_dout to be ready during LOOKUP.
  assign ram_re   = accept_c;
  assign ram_addr = (state_q == IDLE) ? get_index(cpu_addr) : idx_q;

  cache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk       (clk),
    .gen_reset (gen_reset),
    .clear_all (flush_c),
    .rd_en     (accept_c),
    .rd_idx    (get_index(cpu_addr)),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (tag_we_c),
    .wr_idx    (idx_q),
    .wr_tag    (tag_q)
  );

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    tag_we_c    = 1'b0;
    lookup_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        lookup_c = 1'b1;
        if (!req_q.we && hit_c) begin
          cpu_rdata_d = ram_dout;
          cpu_ready_d = 1'b1;
          state_d     = RESP;
        end else begin
          // Every miss and every store goes to memory; only a store hit also updates the RAM.
          mem_req_d   = 1'b1;
          mem_we_d    = req_q.we;
          mem_addr_d  = req_q.addr;
          mem_wdata_d = req_q.wdata;
          if (req_q.we && hit_c) begin
            ram_we_d  = 1'b1;
            ram_din_d = req_q.wdata;
          end
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = RESP;
          if (!req_q.we) begin
            ram_we_d    = 1'b1;
            ram_din_d   = mem_rdata;
            cpu_rdata_d = mem_rdata;
            tag_we_c    = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      req_q     <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept_c) begin
        req_q <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
      end
      cpu_ready <= cpu_ready_d;
      cpu_rdata <= cpu_rdata_d;
      ram_we    <= ram_we_d;
      ram_din   <= ram_din_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating counters, one classification per LOOKUP cycle.
  always_ff @(posedge clk) begin
    if (gen_reset || flush_c) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lookup_c) begin
      if (hit_c && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (!hit_c && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a behavioural data RAM and main-memory responder.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        gen_reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        ram_we;
  logic        ram_re;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  wire  [31:0] ram_dout;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk       (clk),
    .gen_reset (gen_reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // External data RAM: 1-cycle registered read, output floats when no read is pending.
  logic [31:0] ram_model [1024];
  logic [31:0] ram_q = 32'h0;
  logic        ram_q_vld = 1'b0;

  always @(posedge clk) begin
    if (ram_we) ram_model[ram_addr] <= ram_din;
    if (ram_re) ram_q <= ram_model[ram_addr];
    ram_q_vld <= ram_re;
  end
  assign ram_dout = ram_q_vld ? ram_q : 32'hzzzz_zzzz;

  always @(negedge clk) begin
    if (ram_we && ram_re) overlap_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic        got_req;
    logic [15:0] maddr;
    logic        mwe;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        stable;
    logic        timeout;
    logic        re_seen;
    logic [9:0]  raddr_seen;
  } res_t;

  // One CPU transaction; memory acks wait_cyc cycles after mem_req is first seen.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                     input int wait_cyc, input logic [31:0] mdata, output res_t r);
    int waited;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    #1;
    r.re_seen = ram_re;
    r.raddr_seen = ram_addr;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
    r.lat = 1; r.got_req = 1'b0; r.maddr = 16'h0; r.mwe = 1'b0; r.mwd = 32'h0;
    r.rd = 32'h0; r.stable = 1'b1; r.timeout = 1'b1;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_ready) begin
        r.rd = cpu_rdata;
        r.timeout = 1'b0;
        break;
      end
      if (mem_req) begin
        if (!r.got_req) begin
          r.got_req = 1'b1; r.maddr = mem_addr; r.mwe = mem_we; r.mwd = mem_wdata;
        end else if (mem_addr !== r.maddr || mem_we !== r.mwe || mem_wdata !== r.mwd) begin
          r.stable = 1'b0;
        end
        if (waited == wait_cyc) begin
          mem_ack = 1'b1; mem_rdata = mdata;
        end else begin
          waited++;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      r.lat++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    logic seen;
    gen_reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_re", 32'(ram_re), 32'd0);
    @(negedge clk);
    gen_reset = 1'b0;

    // 1: cold load miss with a two-cycle memory wait
    txn(1'b0, 16'h0005, 32'h0, 2, 32'hDEADBEEF, r);
    check_eq("s1_ram_re", 32'(r.re_seen), 32'd1);
    check_eq("s1_ram_addr", 32'(r.raddr_seen), 32'd5);
    check_eq("s1_mem_req", 32'(r.got_req), 32'd1);
    check_eq("s1_mem_addr", 32'(r.maddr), 32'h0005);
    check_eq("s1_mem_we", 32'(r.mwe), 32'd0);
    check_eq("s1_mem_stable", 32'(r.stable), 32'd1);
    check_eq("s1_timeout", 32'(r.timeout), 32'd0);
    check_eq("s1_latency", 32'(r.lat), 32'd5);
    check_eq("s1_rdata", r.rd, 32'hDEADBEEF);
    check_eq("s1_refill", ram_model[5], 32'hDEADBEEF);

    // 2: repeat load hits
    txn(1'b0, 16'h0005, 32'h0, 0, 32'h0, r);
    check_eq("s2_mem_req", 32'(r.got_req), 32'd0);
    check_eq("s2_latency", 32'(r.lat), 32'd2);
    check_eq("s2_rdata", r.rd, 32'hDEADBEEF);

    // 3: store hit writes RAM and memory, then load hits the new value
    txn(1'b1, 16'h0005, 32'h12345678, 1, 32'h0, r);
    check_eq("s3_mem_req", 32'(r.got_req), 32'd1);
    check_eq("s3_mem_we", 32'(r.mwe), 32'd1);
    check_eq("s3_mem_addr", 32'(r.maddr), 32'h0005);
    check_eq("s3_mem_wdata", r.mwd, 32'h12345678);
    check_eq("s3_latency", 32'(r.lat), 32'd4);
    check_eq("s3_ram_write", ram_model[5], 32'h12345678);
    txn(1'b0, 16'h0005, 32'h0, 0, 32'h0, r);
    check_eq("s3_load_mem_req", 32'(r.got_req), 32'd0);
    check_eq("s3_load_rdata", r.rd, 32'h12345678);

    // 4: conflicting tag misses and refills; store miss does not allocate
    txn(1'b0, 16'h0405, 32'h0, 0, 32'hCAFEF00D, r);
    check_eq("s4_mem_req", 32'(r.got_req), 32'd1);
    check_eq("s4_mem_addr", 32'(r.maddr), 32'h0405);
    check_eq("s4_latency", 32'(r.lat), 32'd3);
    check_eq("s4_rdata", r.rd, 32'hCAFEF00D);
    txn(1'b1, 16'h0805, 32'h0BADF00D, 0, 32'h0, r);
    check_eq("s4_st_mem_req", 32'(r.got_req), 32'd1);
    check_eq("s4_st_mem_we", 32'(r.mwe), 32'd1);
    check_eq("s4_st_mem_addr", 32'(r.maddr), 32'h0805);
    check_eq("s4_st_no_alloc", ram_model[5], 32'hCAFEF00D);
`ifdef CACHE_STATS_EN
    check_eq("s6_hit_cnt", hit_cnt, 32'd3);
    check_eq("s6_miss_cnt", miss_cnt, 32'd3);
`endif
    txn(1'b0, 16'h0405, 32'h0, 0, 32'h0, r);
    check_eq("s4_tag_kept", 32'(r.got_req), 32'd0);
    check_eq("s4_tag_kept_rdata", r.rd, 32'hCAFEF00D);

    // 5: flush wins over a simultaneous request
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0005;
    #1;
    check_eq("s5_flush_no_re", 32'(ram_re), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0; cpu_addr = 16'h0;
    seen = 1'b0;
    repeat (3) begin
      if (cpu_ready || mem_req) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("s5_flush_idle", 32'(seen), 32'd0);
`ifdef CACHE_STATS_EN
    check_eq("s6_hit_clr", hit_cnt, 32'd0);
    check_eq("s6_miss_clr", miss_cnt, 32'd0);
`endif
    txn(1'b0, 16'h0405, 32'h0, 0, 32'h55AA55AA, r);
    check_eq("s5_miss_after_flush", 32'(r.got_req), 32'd1);
    check_eq("s5_rdata", r.rd, 32'h55AA55AA);

    // 5b: reset during MEM_WAIT aborts the transaction
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 16'h0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("s5_abort_mem_req", 32'(seen), 32'd1);
    @(negedge clk);
    gen_reset = 1'b1;
    @(posedge clk); #1;
    check_eq("s5_abort_req_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    gen_reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (cpu_ready || mem_req) seen = 1'b1;
    end
    check_eq("s5_abort_no_ready", 32'(seen), 32'd0);
    txn(1'b0, 16'h0005, 32'h0, 0, 32'h0F0F0F0F, r);
    check_eq("s5_reset_invalidates", 32'(r.got_req), 32'd1);
    check_eq("s5_post_reset_rdata", r.rd, 32'h0F0F0F0F);

    check_eq("ram_we_re_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
